// File: rtl/direct_mapped_wb_cache.sv
`default_nettype none
// ============================================================================
// Module   : direct_mapped_wb_cache
// Brief    : Direct-mapped write-back/write-allocate cache, word-serial
//            write-back and refill. Optional hit/miss counters: CACHE_STATS_EN.
// Revision : 1.0
// ============================================================================
module direct_mapped_wb_cache #(
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_Address,
  input  logic [7:0]        cpu_write_data,
  input  logic              read_write,
  output logic [31:0]       cpu_read_data,
  output logic              hit_miss,
  input  logic [31:0]       dm_read_data,
  output logic              dm_read_write,
  output logic [ADDR_W-1:0] dm_address,
`ifdef CACHE_STATS_EN
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
`endif
  output logic [31:0]       dm_write_data
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int WRD_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = ADDR_W - IDX_W - WRD_W - 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_RF = 2'd2} state_t;

  state_t             state_q;
  logic [WRD_W-1:0]   k_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TAG_W-1:0]   new_tag_q;
  logic [TAG_W-1:0]   old_tag_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]   tag_arr_q [NUM_LINES];
  logic [31:0]        data_q    [NUM_LINES][WORDS_PER_LINE];

  logic [IDX_W-1:0]   w_idx;
  logic [WRD_W-1:0]   w_word;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_byte;
  logic               w_hit;
  logic               w_last;

  assign w_idx  = cpu_Address[WRD_W+2 +: IDX_W];
  assign w_word = cpu_Address[2 +: WRD_W];
  assign w_tag  = cpu_Address[ADDR_W-1 -: TAG_W];
  assign w_byte = cpu_Address[1:0];
  assign w_hit  = (state_q == S_IDLE) && valid_q[w_idx] && (tag_arr_q[w_idx] == w_tag);
  assign w_last = (k_q == WRD_W'(WORDS_PER_LINE - 1));

  assign hit_miss      = w_hit;
  assign cpu_read_data = w_hit ? data_q[w_idx][w_word] : 32'd0;

  always_comb begin
    dm_read_write = 1'b0;
    dm_address    = '0;
    dm_write_data = 32'd0;
    case (state_q)
      S_WB: begin
        dm_read_write = 1'b1;
        dm_address    = {old_tag_q, idx_q, k_q, 2'b00};
        dm_write_data = data_q[idx_q][k_q];
      end
      S_RF: begin
        dm_address    = {new_tag_q, idx_q, k_q, 2'b00};
      end
      default: ;
    endcase
  end

  // Data storage carries no reset; validity alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (w_hit && read_write) begin
      data_q[w_idx][w_word][{w_byte, 3'b000} +: 8] <= cpu_write_data;
    end else if (state_q == S_RF) begin
      data_q[idx_q][k_q] <= dm_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      idx_q     <= '0;
      new_tag_q <= '0;
      old_tag_q <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_hit) begin
            if (read_write) dirty_q[w_idx] <= 1'b1;
          end else begin
            idx_q     <= w_idx;
            new_tag_q <= w_tag;
            old_tag_q <= tag_arr_q[w_idx];
            k_q       <= '0;
            state_q   <= (valid_q[w_idx] && dirty_q[w_idx]) ? S_WB : S_RF;
          end
        end
        S_WB: begin
          k_q <= w_last ? '0 : k_q + 1'b1;
          if (w_last) state_q <= S_RF;
        end
        S_RF: begin
          k_q <= w_last ? '0 : k_q + 1'b1;
          if (w_last) begin
            valid_q[idx_q]   <= 1'b1;
            dirty_q[idx_q]   <= 1'b0;
            tag_arr_q[idx_q] <= new_tag_q;
            state_q          <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= 16'd0;
      miss_count_q <= 16'd0;
    end else if (state_q == S_IDLE) begin
      if (w_hit && hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
      if (!w_hit && miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_direct_mapped_wb_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_direct_mapped_wb_cache
// Brief    : Directed bench with word-wide memory model (async read, sync write).
// Revision : 1.0
// ============================================================================
module tb_direct_mapped_wb_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cpu_Address;
  logic [7:0]  cpu_write_data;
  logic        read_write;
  logic [31:0] cpu_read_data;
  logic        hit_miss;
  logic [31:0] dm_read_data;
  logic        dm_read_write;
  logic [9:0]  dm_address;
  logic [31:0] dm_write_data;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  direct_mapped_wb_cache dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_Address    (cpu_Address),
    .cpu_write_data (cpu_write_data),
    .read_write     (read_write),
    .cpu_read_data  (cpu_read_data),
    .hit_miss       (hit_miss),
    .dm_read_data   (dm_read_data),
    .dm_read_write  (dm_read_write),
    .dm_address     (dm_address),
`ifdef CACHE_STATS_EN
    .hit_count      (hit_count),
    .miss_count     (miss_count),
`endif
    .dm_write_data  (dm_write_data)
  );

  assign dm_read_data = mem[dm_address[9:2]];

  always @(posedge clk) begin
    if (dm_read_write) mem[dm_address[9:2]] <= dm_write_data;
  end

  task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  // One CPU access: optional miss-detect cycle, n_wb write-backs, n_rf refills, then the hit.
  task automatic access(input logic [9:0] a, input logic rw, input logic [7:0] wd,
                        input int n_wb, input int n_rf, input logic [3:0] otag,
                        input logic [31:0] wb0, input logic [31:0] exp_rd, input string nm);
    logic [1:0] kk;
    cpu_Address    = a;
    read_write     = rw;
    cpu_write_data = wd;
    if (n_wb + n_rf > 0) begin
      @(negedge clk);
      check({nm, "/det_hit"},  32'(hit_miss), 32'd0);
      check({nm, "/det_addr"}, 32'(dm_address), 32'd0);
      check({nm, "/det_rw"},   32'(dm_read_write), 32'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < n_wb; k++) begin
      kk = 2'(k);
      @(negedge clk);
      check({nm, "/wb_hit"},  32'(hit_miss), 32'd0);
      check({nm, "/wb_rw"},   32'(dm_read_write), 32'd1);
      check({nm, "/wb_addr"}, 32'(dm_address), 32'({otag, a[5:4], kk, 2'b00}));
      check({nm, "/wb_data"}, dm_write_data, (k == 0) ? wb0 : 32'd0);
      check({nm, "/wb_rd"},   cpu_read_data, 32'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < n_rf; k++) begin
      kk = 2'(k);
      @(negedge clk);
      check({nm, "/rf_hit"},  32'(hit_miss), 32'd0);
      check({nm, "/rf_rw"},   32'(dm_read_write), 32'd0);
      check({nm, "/rf_addr"}, 32'(dm_address), 32'({a[9:6], a[5:4], kk, 2'b00}));
      check({nm, "/rf_rd"},   cpu_read_data, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({nm, "/hit"},     32'(hit_miss), 32'd1);
    check({nm, "/rdata"},   cpu_read_data, exp_rd);
    check({nm, "/hit_rw"},  32'(dm_read_write), 32'd0);
    check({nm, "/hit_addr"}, 32'(dm_address), 32'd0);
    check({nm, "/hit_wd"},  dm_write_data, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h83] = 32'hDEAD_BEEF;   // byte address 0x20C
    mem[8'hC0] = 32'h1234_5678;   // byte address 0x300

    rst = 1'b1; cpu_Address = 10'h000; read_write = 1'b0; cpu_write_data = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst/hit",  32'(hit_miss), 32'd0);
    check("rst/rw",   32'(dm_read_write), 32'd0);
    check("rst/addr", 32'(dm_address), 32'd0);
    check("rst/wd",   dm_write_data, 32'd0);
    check("rst/rd",   cpu_read_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    access(10'h000, 1'b0, 8'h00, 0, 4, 4'h0, 32'd0, 32'h0000_0000, "s1_rd000");
    access(10'h000, 1'b1, 8'hFF, 0, 0, 4'h0, 32'd0, 32'h0000_0000, "s2_wr000");
    access(10'h000, 1'b0, 8'h00, 0, 0, 4'h0, 32'd0, 32'h0000_00FF, "s2_rd000");
    check("s2/mem0_untouched", mem[0], 32'd0);
    access(10'h200, 1'b0, 8'h00, 4, 4, 4'h0, 32'h0000_00FF, 32'h0000_0000, "s3_rd200");
    check("s3/mem0_written_back", mem[0], 32'h0000_00FF);
    access(10'h000, 1'b0, 8'h00, 0, 4, 4'h0, 32'd0, 32'h0000_00FF, "s4_rd000");
    access(10'h300, 1'b0, 8'h00, 0, 4, 4'h0, 32'd0, 32'h1234_5678, "s4_rd300");
    access(10'h200, 1'b0, 8'h00, 0, 4, 4'h0, 32'd0, 32'h0000_0000, "s4_rd200");
`ifdef CACHE_STATS_EN
    check("stats/hits",   32'(hit_count),  32'd7);
    check("stats/misses", 32'(miss_count), 32'd5);
`endif

    access(10'h20C, 1'b0, 8'h00, 0, 0, 4'h0, 32'd0, 32'hDEAD_BEEF, "x_rd20C");
    access(10'h016, 1'b1, 8'h5A, 0, 4, 4'h0, 32'd0, 32'h0000_0000, "x_wrmiss016");
    access(10'h014, 1'b0, 8'h00, 0, 0, 4'h0, 32'd0, 32'h005A_0000, "x_rd014");
    access(10'h017, 1'b1, 8'hC3, 0, 0, 4'h0, 32'd0, 32'h005A_0000, "x_wr017");
    access(10'h014, 1'b0, 8'h00, 0, 0, 4'h0, 32'd0, 32'hC35A_0000, "x_rd014b");

    // Reset while the refill of index 2 is on its third word.
    cpu_Address = 10'h020; read_write = 1'b0;
    @(negedge clk);
    check("s5/det_hit", 32'(hit_miss), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("s5/rf2_addr", 32'(dm_address), 32'h028);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("s5/post_hit",  32'(hit_miss), 32'd0);
    check("s5/post_rw",   32'(dm_read_write), 32'd0);
    check("s5/post_addr", 32'(dm_address), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(10'h014, 1'b0, 8'h00, 0, 4, 4'h0, 32'd0, 32'h0000_0000, "s5_rd014");
    check("s5/dirty_discarded", mem[5], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
